toy_bus_ack_dec_node_2: RTL and testbench

- 1-to-2 demultiplexing node for ToyBusAck traffic in the bus network.
- It is the splitting counterpart of the 2-to-1 age-matrix arbitration node: one ack stream enters and is steered to one of two downstream ports by tgt_id.
- Each output has a 2-entry registered FIFO, so no combinational path exists from out*_rdy to in0_rdy.
- This breaks timing between network hops and sustains 1 beat/cycle per output.

---
 rtl/toy_bus_ack_dec_node_2.sv | 127 ++++++++++++
 tb/tb_toy_bus_ack_dec_node_2.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_ack_dec_node_2.sv
// toy_bus_ack_dec_node_2
//   1-to-2 demux for ToyBusAck beats. A single input stream is steered to
//   out0 or out1 by tgt_id (tgt_id >= OUT1_ID_MIN -> out1). Each output owns
//   a 2-entry registered FIFO, so the input ready never combinationally
//   depends on downstream ready, and each output still sustains 1 beat/cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in0_vld/in0_rdy       input handshake
//   in0_opcode/data/sideband/src_id/tgt_id   input beat fields
//   outN_vld/outN_rdy     output handshake (N = 0, 1)
//   outN_opcode/data/sideband/src_id/tgt_id  forwarded beat fields

// 2-entry FIFO holding one output's beats. Head is always registered.
module toy_bus_ack_dec_node_2_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic         vld,
  output logic         full,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [0:1];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;
  logic         pop;

  assign vld  = (cnt != 2'd0);
  assign full = (cnt == 2'd2);
  assign pop  = vld && rdy;
  assign dout = mem[rd_ptr];

  // The parent never pushes while full, so push+pop only occurs at cnt==1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module toy_bus_ack_dec_node_2 #(
  parameter int DATA_W      = 256,
  parameter int SB_W        = 10,
  parameter int ID_W        = 4,
  parameter int OUT1_ID_MIN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [SB_W-1:0]   in0_sideband,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic              out0_opcode,
  output logic [DATA_W-1:0] out0_data,
  output logic [SB_W-1:0]   out0_sideband,
  output logic [ID_W-1:0]   out0_src_id,
  output logic [ID_W-1:0]   out0_tgt_id,
  output logic              out1_vld,
  input  logic              out1_rdy,
  output logic              out1_opcode,
  output logic [DATA_W-1:0] out1_data,
  output logic [SB_W-1:0]   out1_sideband,
  output logic [ID_W-1:0]   out1_src_id,
  output logic [ID_W-1:0]   out1_tgt_id
);
  localparam int NUM_OUT = 2;
  localparam int EW      = 1 + DATA_W + SB_W + 2*ID_W;
  // One extra bit so a threshold of 2**ID_W (nothing to out1) still compares correctly.
  localparam logic [ID_W:0] MIN_ID = OUT1_ID_MIN[ID_W:0];

  logic                        sel;
  logic [EW-1:0]               ent;
  logic [NUM_OUT-1:0]          route, push, rdy, vld, full;
  logic [NUM_OUT-1:0][EW-1:0]  dout;

  assign sel   = ({1'b0, in0_tgt_id} >= MIN_ID);
  assign route = {sel, ~sel};
  assign ent   = {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};

  // Head-of-line blocking: readiness is that of the targeted FIFO only,
  // and comes from registered counts, not from downstream ready.
  assign in0_rdy = sel ? ~full[1] : ~full[0];
  assign push    = {NUM_OUT{in0_vld && in0_rdy}} & route;
  assign rdy     = {out1_rdy, out0_rdy};

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
    toy_bus_ack_dec_node_2_fifo #(.W(EW)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[n]),
      .din  (ent),
      .rdy  (rdy[n]),
      .vld  (vld[n]),
      .full (full[n]),
      .dout (dout[n])
    );
  end

  assign out0_vld = vld[0];
  assign out1_vld = vld[1];
  assign {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id} = dout[0];
  assign {out1_opcode, out1_data, out1_sideband, out1_src_id, out1_tgt_id} = dout[1];
endmodule

// File: tb/tb_toy_bus_ack_dec_node_2.sv
module tb_toy_bus_ack_dec_node_2;
  localparam int DATA_W = 256;
  localparam int SB_W   = 10;
  localparam int ID_W   = 4;
  localparam int EW     = 1 + DATA_W + SB_W + 2*ID_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in0_vld = 1'b0;
  logic              in0_rdy;
  logic              in0_opcode = 1'b0;
  logic [DATA_W-1:0] in0_data = '0;
  logic [SB_W-1:0]   in0_sideband = '0;
  logic [ID_W-1:0]   in0_src_id = '0;
  logic [ID_W-1:0]   in0_tgt_id = '0;
  logic              out0_vld, out1_vld;
  logic              out0_rdy = 1'b1;
  logic              out1_rdy = 1'b1;
  logic              out0_opcode, out1_opcode;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic [SB_W-1:0]   out0_sideband, out1_sideband;
  logic [ID_W-1:0]   out0_src_id, out1_src_id, out0_tgt_id, out1_tgt_id;

  toy_bus_ack_dec_node_2 dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_opcode(in0_opcode),
    .in0_data(in0_data), .in0_sideband(in0_sideband),
    .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
    .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_opcode(out0_opcode),
    .out0_data(out0_data), .out0_sideband(out0_sideband),
    .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id),
    .out1_vld(out1_vld), .out1_rdy(out1_rdy), .out1_opcode(out1_opcode),
    .out1_data(out1_data), .out1_sideband(out1_sideband),
    .out1_src_id(out1_src_id), .out1_tgt_id(out1_tgt_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] in_ent();
    return {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};
  endfunction
  function automatic logic [EW-1:0] out0_ent();
    return {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id};
  endfunction
  function automatic logic [EW-1:0] out1_ent();
    return {out1_opcode, out1_data, out1_sideband, out1_src_id, out1_tgt_id};
  endfunction

  task automatic set_beat(input logic op, input logic [DATA_W-1:0] d,
                          input logic [SB_W-1:0] sb, input logic [ID_W-1:0] src,
                          input logic [ID_W-1:0] tgt);
    in0_vld      = 1'b1;
    in0_opcode   = op;
    in0_data     = d;
    in0_sideband = sb;
    in0_src_id   = src;
    in0_tgt_id   = tgt;
  endtask

  // One clock of stimulus: sample handshake at negedge, record expectation
  // for an accepted beat, return just after the next posedge.
  task automatic accept_cycle(output bit acc);
    @(negedge clk);
    acc = in0_vld && in0_rdy;
    if (acc) begin
      if (in0_tgt_id >= 4'd8) q1.push_back(in_ent());
      else                    q0.push_back(in_ent());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in0_vld    = 1'b0;
    in0_tgt_id = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every handshake on an output pops and compares.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_vld && out0_rdy) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out0_unexpected: got %0h expected none", out0_ent());
        end else chk("out0_beat", out0_ent(), q0.pop_front());
      end
      if (out1_vld && out1_rdy) begin
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out1_unexpected: got %0h expected none", out1_ent());
        end else chk("out1_beat", out1_ent(), q1.pop_front());
      end
    end
  end

  initial begin : stim
    bit a;
    logic [EW-1:0] b1;

    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0_vld", out0_vld, 0);
    chk("rst_out1_vld", out1_vld, 0);
    chk("rst_out0_pay", out0_ent(), 0);
    chk("rst_out1_pay", out1_ent(), 0);
    chk("rst_in0_rdy", in0_rdy, 1);
    rst = 1'b0;
    idle(1);

    // single routing
    set_beat(1'b0, {32{8'hA5}}, 10'h155, 4'h1, 4'd3);
    accept_cycle(a);
    chk("r3_acc", a, 1);
    in0_vld = 1'b0;
    chk("r3_out0_vld", out0_vld, 1);
    chk("r3_out1_vld", out1_vld, 0);
    set_beat(1'b1, {32{8'h5A}}, 10'h2AA, 4'h2, 4'd8);
    accept_cycle(a);
    chk("r8_acc", a, 1);
    in0_vld = 1'b0;
    chk("r8_out1_vld", out1_vld, 1);
    chk("r8_out0_vld", out0_vld, 0);
    set_beat(1'b0, {8{32'hDEADBEEF}}, 10'h3FF, 4'hF, 4'd15);
    accept_cycle(a);
    chk("r15_acc", a, 1);
    in0_vld = 1'b0;
    chk("r15_out1_vld", out1_vld, 1);
    chk("r15_out0_vld", out0_vld, 0);
    set_beat(1'b1, {8{32'h01234567}}, 10'h001, 4'h3, 4'd7);
    accept_cycle(a);
    chk("r7_acc", a, 1);
    in0_vld = 1'b0;
    chk("r7_out0_vld", out0_vld, 1);
    chk("r7_out1_vld", out1_vld, 0);
    idle(3);

    // backpressure fill on out0
    out0_rdy = 1'b0;
    set_beat(1'b0, 256'h1111, 10'h011, 4'h4, 4'd2);
    b1 = in_ent();
    accept_cycle(a); chk("bp_b1_acc", a, 1);
    set_beat(1'b1, 256'h2222, 10'h022, 4'h5, 4'd2);
    accept_cycle(a); chk("bp_b2_acc", a, 1);
    set_beat(1'b0, 256'h3333, 10'h033, 4'h6, 4'd2);
    accept_cycle(a); chk("bp_b3_block", a, 0);
    accept_cycle(a); chk("bp_b3_block2", a, 0);
    chk("bp_hold_vld", out0_vld, 1);
    chk("bp_hold_pay", out0_ent(), b1);
    out0_rdy = 1'b1;
    accept_cycle(a); chk("bp_no_push_on_pop", a, 0);
    accept_cycle(a); chk("bp_b3_acc", a, 1);
    idle(4);

    // streaming throughput
    for (int i = 0; i < 32; i++) begin
      set_beat(i[0], DATA_W'(i), SB_W'(i), 4'h7, 4'd1);
      accept_cycle(a);
      chk("stream_acc", a, 1);
      chk("stream_out0_vld", out0_vld, 1);
    end
    idle(3);
    chk("stream_drained", out0_vld, 0);

    // head-of-line isolation
    out1_rdy = 1'b0;
    set_beat(1'b0, 256'h9001, 10'h091, 4'h8, 4'd9);
    accept_cycle(a); chk("hol_f1_acc", a, 1);
    set_beat(1'b1, 256'h9002, 10'h092, 4'h8, 4'd10);
    accept_cycle(a); chk("hol_f2_acc", a, 1);
    set_beat(1'b0, 256'h9003, 10'h093, 4'h8, 4'd11);
    accept_cycle(a); chk("hol_block1", a, 0);
    chk("hol_out0_idle1", out0_vld, 0);
    accept_cycle(a); chk("hol_block2", a, 0);
    chk("hol_out0_idle2", out0_vld, 0);
    out1_rdy = 1'b1;
    accept_cycle(a); chk("hol_pop_block", a, 0);
    accept_cycle(a); chk("hol_out1_acc", a, 1);
    set_beat(1'b1, 256'h4004, 10'h044, 4'h9, 4'd4);
    accept_cycle(a); chk("hol_out0_acc", a, 1);
    chk("hol_out0_vld", out0_vld, 1);
    idle(4);

    // reset mid-operation with both FIFOs full
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    set_beat(1'b0, 256'hA1, 10'h0A1, 4'hA, 4'd5);  accept_cycle(a); chk("mr_a1", a, 1);
    set_beat(1'b1, 256'hB1, 10'h0B1, 4'hB, 4'd12); accept_cycle(a); chk("mr_b1", a, 1);
    set_beat(1'b0, 256'hA2, 10'h0A2, 4'hA, 4'd6);  accept_cycle(a); chk("mr_a2", a, 1);
    set_beat(1'b1, 256'hB2, 10'h0B2, 4'hB, 4'd13); accept_cycle(a); chk("mr_b2", a, 1);
    in0_vld = 1'b0;
    chk("mr_full_out0", out0_vld, 1);
    chk("mr_full_out1", out1_vld, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_out0_vld", out0_vld, 0);
    chk("mr_out1_vld", out1_vld, 0);
    chk("mr_out0_pay", out0_ent(), 0);
    chk("mr_out1_pay", out1_ent(), 0);
    chk("mr_in0_rdy", in0_rdy, 1);
    q0.delete();
    q1.delete();
    rst = 1'b0;
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    idle(5);
    chk("post_rst_out0_vld", out0_vld, 0);
    chk("post_rst_out1_vld", out1_vld, 0);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
